scratch_mem: RTL and testbench

Scratch memory responder that serves the equalizer's divider stage: two synchronous read ports feed CDF words to the divider datapath, and one write port accepts the divided (equalized) results. The block also tracks pass completion from the client's read-done and write-done strobes, counts accepted writes and flags out-of-range accesses. It sits between the divider top level and the rest of the pipeline as the memory end of the `div_sc_mem_*` interface.

---
 rtl/scratch_mem.sv | 164 ++++++++++++++++
 tb/tb_scratch_mem.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scratch_mem.sv
// Dual-read / single-write scratch memory for the equalizer divider stage.
// Tracks pass completion, counts accepted writes and flags bad addresses.
module scratch_mem #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wt_en,
    input  logic [ADDR_W-1:0] wt_addr,
    input  logic [DATA_W-1:0] wt_data,
    input  logic              rd_done,
    input  logic              wt_done,
    input  logic              clear,
    output logic              busy,
    output logic              pass_done,
    output logic [ADDR_W-1:0] wt_count,
    output logic              addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_e;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              wr_ok;
    logic              rd_ok1;
    logic              rd_ok2;
    logic [IDX_W-1:0]  wt_idx;

    logic [IDX_W-1:0]  rd_idx1_q, rd_idx1_d;
    logic [IDX_W-1:0]  rd_idx2_q, rd_idx2_d;
    logic              rd_vld1_q, rd_vld1_d;
    logic              rd_vld2_q, rd_vld2_d;
    logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0] rd_data2_q, rd_data2_d;

    state_e            state_q, state_d;
    logic              rd_seen_q, rd_seen_d;
    logic              wt_seen_q, wt_seen_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    assign wr_ok  = wt_en && ({1'b0, wt_addr} < DEPTH_L);
    assign rd_ok1 = {1'b0, rd_addr1} < DEPTH_L;
    assign rd_ok2 = {1'b0, rd_addr2} < DEPTH_L;
    assign wt_idx = wt_addr[IDX_W-1:0];

    // Array is deliberately left out of reset; words survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wt_idx] <= wt_data;
        end
    end

    // Stage 2 forwards a write landing on the same edge (write-first).
    always_comb begin
        rd_idx1_d  = rd_addr1[IDX_W-1:0];
        rd_idx2_d  = rd_addr2[IDX_W-1:0];
        rd_vld1_d  = rd_ok1;
        rd_vld2_d  = rd_ok2;
        rd_data1_d = '0;
        rd_data2_d = '0;
        if (rd_vld1_q) begin
            rd_data1_d = (wr_ok && wt_idx == rd_idx1_q) ? wt_data
                                                        : mem_q[rd_idx1_q];
        end
        if (rd_vld2_q) begin
            rd_data2_d = (wr_ok && wt_idx == rd_idx2_q) ? wt_data
                                                        : mem_q[rd_idx2_q];
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_seen_d = rd_seen_q;
        wt_seen_d = wt_seen_q;
        cnt_d     = cnt_q;
        err_d     = err_q | (wt_en & ~wr_ok) | ~rd_ok1 | ~rd_ok2;
        if (clear) begin
            state_d   = S_IDLE;
            rd_seen_d = 1'b0;
            wt_seen_d = 1'b0;
            cnt_d     = '0;
            err_d     = 1'b0;
        end else begin
            if (wr_ok && state_q != S_DONE && cnt_q != '1) begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
            unique case (state_q)
                S_IDLE, S_ACTIVE: begin
                    rd_seen_d = rd_seen_q | rd_done;
                    wt_seen_d = wt_seen_q | wt_done;
                    if (rd_seen_d && wt_seen_d) begin
                        state_d = S_DONE;
                    end else if (wr_ok || rd_done || wt_done) begin
                        state_d = S_ACTIVE;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d == S_ACTIVE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_idx1_q  <= '0;
            rd_idx2_q  <= '0;
            rd_vld1_q  <= 1'b0;
            rd_vld2_q  <= 1'b0;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            state_q    <= S_IDLE;
            rd_seen_q  <= 1'b0;
            wt_seen_q  <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_idx1_q  <= rd_idx1_d;
            rd_idx2_q  <= rd_idx2_d;
            rd_vld1_q  <= rd_vld1_d;
            rd_vld2_q  <= rd_vld2_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            state_q    <= state_d;
            rd_seen_q  <= rd_seen_d;
            wt_seen_q  <= wt_seen_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rd_data1  = rd_data1_q;
    assign rd_data2  = rd_data2_q;
    assign busy      = busy_q;
    assign pass_done = done_q;
    assign wt_count  = cnt_q;
    assign addr_err  = err_q;

endmodule

// File: tb/tb_scratch_mem.sv
// Scoreboard bench for scratch_mem: directed cases then random traffic
// against an array-and-counters reference model.
module tb_scratch_mem;

    localparam int DW    = 128;
    localparam int AW    = 16;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rd_addr1 = '0;
    logic [AW-1:0] rd_addr2 = '0;
    logic [DW-1:0] rd_data1;
    logic [DW-1:0] rd_data2;
    logic          wt_en = 1'b0;
    logic [AW-1:0] wt_addr = '0;
    logic [DW-1:0] wt_data = '0;
    logic          rd_done = 1'b0;
    logic          wt_done = 1'b0;
    logic          clear = 1'b0;
    logic          busy;
    logic          pass_done;
    logic [AW-1:0] wt_count;
    logic          addr_err;

    always #5 clk = ~clk;

    scratch_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wt_en    (wt_en),
        .wt_addr  (wt_addr),
        .wt_data  (wt_data),
        .rd_done  (rd_done),
        .wt_done  (wt_done),
        .clear    (clear),
        .busy     (busy),
        .pass_done(pass_done),
        .wt_count (wt_count),
        .addr_err (addr_err)
    );

    typedef struct {
        int unsigned   edge_no;
        bit            chk1;
        bit            chk2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        bit            busy;
        bit            done;
        bit            err;
        int            cnt;
    } exp_t;

    exp_t          sbq[$];
    int unsigned   edges = 0;
    int            tests = 0;
    int            fails = 0;

    // Reference model: plain array plus pass bookkeeping.
    logic [DW-1:0] mdl_mem [DEPTH];
    bit            mdl_wr [DEPTH];
    int            phase = 0;
    int            cnt = 0;
    bit            rs = 0;
    bit            ws = 0;
    bit            err = 0;
    logic [AW-1:0] pa1 = AW'(DEPTH);
    logic [AW-1:0] pa2 = AW'(DEPTH);

    function automatic void chk(string nm, logic [DW-1:0] act,
                                logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @edge %0d: got %h want %h", nm, edges, act, exp);
        end
    endfunction

    function automatic void read_exp(input logic [AW-1:0] a, output bit c,
                                     output logic [DW-1:0] v);
        int ia;
        ia = int'(a);
        if (ia >= DEPTH) begin
            c = 1'b1;
            v = '0;
        end else begin
            c = mdl_wr[ia];
            v = mdl_mem[ia];
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            edges++;
            #1;
            while (sbq.size() > 0 && sbq[0].edge_no <= edges) begin
                e = sbq.pop_front();
                if (e.edge_no != edges) begin
                    chk("missed_edge", DW'(e.edge_no), DW'(edges));
                end else begin
                    if (e.chk1) chk("rd_data1", rd_data1, e.e1);
                    if (e.chk2) chk("rd_data2", rd_data2, e.e2);
                    chk("busy", DW'(busy), DW'(e.busy));
                    chk("pass_done", DW'(pass_done), DW'(e.done));
                    chk("addr_err", DW'(addr_err), DW'(e.err));
                    chk("wt_count", DW'(wt_count), DW'(e.cnt));
                end
            end
        end
    end

    // Called at a falling edge; drives one cycle and returns at the next one.
    task automatic step(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input bit we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input bit rdd,
                        input bit wtd, input bit clr);
        exp_t e;
        bit   w_ok;
        bit   bad;
        rd_addr1 = a1;
        rd_addr2 = a2;
        wt_en    = we;
        wt_addr  = wa;
        wt_data  = wd;
        rd_done  = rdd;
        wt_done  = wtd;
        clear    = clr;
        w_ok = we && (int'(wa) < DEPTH);
        bad  = (we && !w_ok) || int'(a1) >= DEPTH || int'(a2) >= DEPTH;
        if (w_ok) begin
            mdl_mem[int'(wa)] = wd;
            mdl_wr[int'(wa)]  = 1'b1;
        end
        e.edge_no = edges + 1;
        read_exp(pa1, e.chk1, e.e1);
        read_exp(pa2, e.chk2, e.e2);
        pa1 = a1;
        pa2 = a2;
        if (clr) begin
            phase = 0;
            cnt   = 0;
            rs    = 0;
            ws    = 0;
            err   = 0;
        end else begin
            if (bad) err = 1;
            if (phase != 2) begin
                if (w_ok && cnt < 65535) cnt++;
                rs = rs | rdd;
                ws = ws | wtd;
                if (rs && ws) phase = 2;
                else if (w_ok || rdd || wtd) phase = 1;
            end
        end
        e.busy = (phase == 1);
        e.done = (phase == 2);
        e.cnt  = cnt;
        e.err  = err;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 0, '0, '0, 0, 0, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // first post-reset edge must present zeros on both ports
        pa1 = AW'(DEPTH);
        pa2 = AW'(DEPTH);
    endtask

    task automatic do_reset();
        rd_addr1 = '0;
        rd_addr2 = '0;
        wt_en    = 1'b0;
        rd_done  = 1'b0;
        wt_done  = 1'b0;
        clear    = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_rd_data1", rd_data1, '0);
        chk("rst_rd_data2", rd_data2, '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_pass_done", DW'(pass_done), '0);
        chk("rst_wt_count", DW'(wt_count), '0);
        chk("rst_addr_err", DW'(addr_err), '0);
        sbq.delete();
        phase = 0;
        cnt   = 0;
        rs    = 0;
        ws    = 0;
        err   = 0;
        release_reset();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 63);
        if (r == 0) return AW'($urandom_range(DEPTH, 400));
        if (r < 32) return AW'($urandom_range(0, 15));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [DW-1:0] aa;
        aa = {16{8'hAA}};
        for (int i = 0; i < DEPTH; i++) mdl_wr[i] = 1'b0;
        @(negedge clk);
        do_reset();

        step('0, '0, 1, 16'd5, DW'(1), 0, 0, 0);
        step('0, '0, 1, 16'd6, DW'(2), 0, 0, 0);
        step(16'd5, 16'd6, 0, '0, '0, 0, 0, 0);
        idle(2);

        step(16'd10, '0, 1, 16'd10, aa, 0, 0, 0);
        idle(2);

        step('0, '0, 1, 16'd44, DW'(44), 0, 0, 0);
        step('0, '0, 1, 16'd300, rand_data(), 0, 0, 0);
        step(16'd300, 16'd44, 0, '0, '0, 0, 0, 0);
        idle(2);
        step('0, '0, 0, '0, '0, 0, 0, 1);
        idle(1);

        for (int i = 0; i < 8; i++) begin
            step('0, '0, 1, AW'(20 + i), rand_data(), 0, 0, 0);
        end
        step('0, '0, 0, '0, '0, 0, 1, 0);
        idle(2);
        step('0, '0, 0, '0, '0, 1, 0, 0);
        idle(2);
        step('0, '0, 0, '0, '0, 0, 0, 1);
        idle(1);

        step('0, '0, 0, '0, '0, 1, 1, 0);
        idle(1);
        step('0, '0, 1, 16'd7, DW'(77), 0, 0, 1);
        step(16'd7, 16'd20, 0, '0, '0, 0, 0, 0);
        idle(2);

        step(16'd5, 16'd6, 0, '0, '0, 0, 0, 0);
        step(16'd6, 16'd5, 0, '0, '0, 0, 0, 0);
        do_reset();
        step(16'd5, 16'd6, 0, '0, '0, 0, 0, 0);
        step(16'd6, 16'd5, 0, '0, '0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step(rand_addr(), rand_addr(), $urandom_range(0, 1) == 1,
                     rand_addr(), rand_data(),
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 59) == 0);
            end
        end
        idle(3);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", DW'(sbq.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
